// File: rtl/ram_pkg.sv
// ram_pkg: shared lane width, clear-FSM state type and byte-lane extraction helper
// Used by byte_lane_ram and byte_lane_ram_lane via import ram_pkg::*.
package ram_pkg;
    localparam int LANE_W = 8;
    localparam int MAX_DATA_W = 256;
    typedef enum logic {CLEAR, READY} ram_state_e;
    // Callers zero-extend their data word to MAX_DATA_W so one helper serves any lane count.
    function automatic logic [LANE_W-1:0] lane_sel(input logic [MAX_DATA_W-1:0] data, input int unsigned k);
        return data[k*LANE_W +: LANE_W];
    endfunction
endpackage

// File: rtl/byte_lane_ram_lane.sv
// byte_lane_ram_lane: one 8-bit x DEPTH block-RAM lane, one write port and one registered read port
// Ports:
//   clk      in   clock
//   rst      in   sync active-high reset, clears only the read register
//   we_i     in   write strobe (already qualified by the caller)
//   waddr_i  in   write word address
//   wdata_i  in   write byte
//   re_i     in   read strobe (already qualified by the caller)
//   raddr_i  in   read word address
//   rdata_o  out  registered read byte, holds when re_i=0
module byte_lane_ram_lane
    import ram_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [LANE_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [LANE_W-1:0] rdata_o
);
    logic [LANE_W-1:0] mem_q [DEPTH];
    logic [LANE_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    always_ff @(posedge clk) begin
        if (rst) rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/byte_lane_ram.sv
// byte_lane_ram: byte-lane RAM with clear-on-reset sequencer, address guard, write-first forwarding and read-valid
// Ports:
//   clk, rst        clock; sync active-high reset (acts regardless of clk_en)
//   clk_en          global stall, 0 freezes all state including the array
//   i_read_enable   read request;  i_read_addr word address
//   o_read_data     read data (lane 0 = LSB); o_read_valid one pulse per accepted read
//   i_write_enable  per-lane strobe; i_write_addr word address; i_write_data write data
//   o_busy          clear sequence running, requests ignored
// Optional: define BYTE_LANE_RAM_OUT_REG_EN for an extra output register (read latency 2).
module byte_lane_ram
    import ram_pkg::*;
#(
    parameter int NUM_LANES      = 4,
    parameter int DEPTH          = 1024,
    parameter int ADDR_W         = $clog2(DEPTH),
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic                        i_read_enable,
    input  logic [ADDR_W-1:0]           i_read_addr,
    output logic [LANE_W*NUM_LANES-1:0] o_read_data,
    output logic                        o_read_valid,
    input  logic [NUM_LANES-1:0]        i_write_enable,
    input  logic [ADDR_W-1:0]           i_write_addr,
    input  logic [LANE_W*NUM_LANES-1:0] i_write_data,
    output logic                        o_busy
);
    localparam int DATA_W = LANE_W * NUM_LANES;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    ram_state_e state_q, state_d;
    logic [ADDR_W-1:0] clr_q, clr_d;
    logic valid_q, oor_q;
    logic [NUM_LANES-1:0] fwd_q, fwd_d;
    logic [DATA_W-1:0] fwd_data_q, rd_data;
    logic ready, rd_oor, wr_oor, rd_acc, wr_ok, clr_we;

    assign ready  = state_q == READY;
    assign rd_oor = {1'b0, i_read_addr} >= LIMIT;
    assign wr_oor = {1'b0, i_write_addr} >= LIMIT;
    assign rd_acc = clk_en && ready && i_read_enable;
    assign wr_ok  = clk_en && !rst && ready && !wr_oor;
    assign clr_we = clk_en && !rst && !ready;
    assign o_busy = !ready;

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        if (!ready) begin
            clr_d = clr_q + ADDR_W'(1);
            if (clr_q == LAST) begin
                state_d = READY;
                clr_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_q      <= '0;
            valid_q    <= 1'b0;
            fwd_q      <= '0;
            fwd_data_q <= '0;
            oor_q      <= 1'b0;
        end else if (clk_en) begin
            state_q <= state_d;
            clr_q   <= clr_d;
            valid_q <= rd_acc;
            // Read-side steering is captured with the read so the output holds between reads.
            if (rd_acc) begin
                fwd_q      <= fwd_d;
                fwd_data_q <= i_write_data;
                oor_q      <= rd_oor;
            end
        end
    end

    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        logic [LANE_W-1:0] lane_q;
        assign fwd_d[k] = wr_ok && i_write_enable[k] && (i_write_addr == i_read_addr);
        byte_lane_ram_lane #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .we_i   (clr_we || (wr_ok && i_write_enable[k])),
            .waddr_i(ready ? i_write_addr : clr_q),
            .wdata_i(ready ? lane_sel(MAX_DATA_W'(i_write_data), k) : '0),
            .re_i   (rd_acc && !rd_oor),
            .raddr_i(i_read_addr),
            .rdata_o(lane_q)
        );
        // Write-first per lane: a same-cycle write to the read address wins over the array byte.
        assign rd_data[k*LANE_W +: LANE_W] = oor_q ? '0 :
                                             fwd_q[k] ? lane_sel(MAX_DATA_W'(fwd_data_q), k) : lane_q;
    end

`ifdef BYTE_LANE_RAM_OUT_REG_EN
    logic [DATA_W-1:0] out_data_q;
    logic out_valid_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else if (clk_en) begin
            out_data_q  <= rd_data;
            out_valid_q <= valid_q;
        end
    end
    assign o_read_data  = out_data_q;
    assign o_read_valid = out_valid_q;
`else
    assign o_read_data  = rd_data;
    assign o_read_valid = valid_q;
`endif
endmodule

// File: tb/tb_byte_lane_ram.sv
// tb_byte_lane_ram: randomized + directed self-checking bench for byte_lane_ram (DEPTH 16 and 12 side by side)
module tb_byte_lane_ram;
`ifdef BYTE_LANE_RAM_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int DEP [2] = '{16, 12};

    logic clk = 0, rst, clk_en, re;
    logic [3:0] raddr, waddr, we;
    logic [31:0] wd;
    logic [31:0] rd16, rd12;
    logic v16, v12, b16, b12;

    int checks = 0, errors = 0;
    bit started = 0;

    logic [31:0] mem [2][16];
    bit busy [2];
    int cnt [2];
    bit s1_v [2], o_v [2];
    logic [31:0] s1_d [2], o_d [2];

    always #5 clk = ~clk;

    byte_lane_ram #(.NUM_LANES(4), .DEPTH(16), .CLEAR_ON_RESET(1)) u16 (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .i_read_enable(re), .i_read_addr(raddr), .o_read_data(rd16), .o_read_valid(v16),
        .i_write_enable(we), .i_write_addr(waddr), .i_write_data(wd), .o_busy(b16)
    );

    byte_lane_ram #(.NUM_LANES(4), .DEPTH(12), .CLEAR_ON_RESET(1)) u12 (
        .clk(clk), .rst(rst), .clk_en(clk_en),
        .i_read_enable(re), .i_read_addr(raddr), .o_read_data(rd12), .o_read_valid(v12),
        .i_write_enable(we), .i_write_addr(waddr), .i_write_data(wd), .o_busy(b12)
    );

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: memory as plain words, a 1-deep result plus an optional extra output stage.
    task automatic model_step();
        logic [31:0] r;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                busy[d] = 1; cnt[d] = 0;
                s1_v[d] = 0; s1_d[d] = 0; o_v[d] = 0; o_d[d] = 0;
                continue;
            end
            if (!clk_en) continue;
            if (LAT == 2) begin
                o_v[d] = s1_v[d];
                o_d[d] = s1_d[d];
            end
            if (busy[d]) begin
                mem[d][cnt[d]] = 0;
                cnt[d]++;
                if (cnt[d] == DEP[d]) busy[d] = 0;
                s1_v[d] = 0;
            end else begin
                s1_v[d] = re;
                if (re) begin
                    r = 0;
                    if (int'(raddr) < DEP[d])
                        for (int k = 0; k < 4; k++)
                            r[8*k +: 8] = (we[k] && waddr == raddr) ? wd[8*k +: 8] : mem[d][raddr][8*k +: 8];
                    s1_d[d] = r;
                end
                if (int'(waddr) < DEP[d])
                    for (int k = 0; k < 4; k++)
                        if (we[k]) mem[d][waddr][8*k +: 8] = wd[8*k +: 8];
            end
            if (LAT == 1) begin
                o_v[d] = s1_v[d];
                o_d[d] = s1_d[d];
            end
        end
    endtask

    task automatic check();
        if (!started) return;
        cmp("busy16", 32'(b16), 32'(busy[0]));
        cmp("valid16", 32'(v16), 32'(o_v[0]));
        cmp("data16", rd16, o_d[0]);
        cmp("busy12", 32'(b12), 32'(busy[1]));
        cmp("valid12", 32'(v12), 32'(o_v[1]));
        cmp("data12", rd12, o_d[1]);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check();
    endtask

    task automatic idle();
        re = 0; we = 0;
    endtask

    task automatic rd(input logic [3:0] a);
        re = 1; raddr = a; we = 0;
        tick();
        re = 0;
        if (LAT == 2) tick();
    endtask

    initial begin
        int n16, n12;
        bit vseen;
        rst = 1; clk_en = 1; raddr = 0; waddr = 0; wd = 0;
        idle();
        @(negedge clk);
        started = 1;
        tick();
        cmp("rst_busy", 32'(b16), 32'd1);
        cmp("rst_valid", 32'(v16), 32'd0);
        cmp("rst_data", rd16, 32'd0);
        rst = 0;
        n16 = int'(b16); n12 = int'(b12);
        for (int i = 0; i < 40 && (b16 || b12); i++) begin
            tick();
            n16 += int'(b16); n12 += int'(b12);
        end
        cmp("clear_len16", 32'(n16), 32'd16);
        cmp("clear_len12", 32'(n12), 32'd12);

        for (int a = 0; a < 16; a++) begin
            rd(4'(a));
            cmp("clr_rd_v", 32'(v16), 32'd1);
            cmp("clr_rd_d", rd16, 32'd0);
        end

        we = 4'hF; waddr = 3; wd = 32'hDEADBEEF; tick();
        we = 4'h1; wd = 32'h000000AA; tick();
        rd(3);
        cmp("bytewr16", rd16, 32'hDEADBEAA);
        cmp("bytewr12", rd12, 32'hDEADBEAA);

        we = 4'hF; waddr = 5; wd = 32'h11223344; tick();
        re = 1; raddr = 5; we = 4'hA; wd = 32'hAABBCCDD; tick();
        idle();
        if (LAT == 2) tick();
        cmp("fwd16", rd16, 32'hAA22CC44);
        cmp("fwd12", rd12, 32'hAA22CC44);

        we = 4'hF; waddr = 2; wd = 32'h0BADF00D; tick();
        rd(2);
        cmp("stall_pre", rd16, 32'h0BADF00D);
        clk_en = 0; we = 4'hF; waddr = 2; wd = 32'h12345678; re = 1; raddr = 7;
        repeat (3) begin
            tick();
            cmp("stall_v", 32'(v16), 32'd1);
            cmp("stall_d", rd16, 32'h0BADF00D);
        end
        clk_en = 1;
        rd(2);
        cmp("stall_nowrite", rd16, 32'h0BADF00D);

        we = 4'hF; waddr = 13; wd = 32'hFFFFFFFF; tick();
        we = 0; re = 1; raddr = 13; tick();
        re = 0;
        if (LAT == 2) begin
            cmp("oor_lat_v0", 32'(v12), 32'd0);
            tick();
        end
        cmp("oor_v", 32'(v12), 32'd1);
        cmp("oor_d", rd12, 32'd0);
        cmp("inrange13", rd16, 32'hFFFFFFFF);

        rst = 1; tick(); rst = 0;
        repeat (7) tick();
        rst = 1; re = 1; raddr = 1; we = 4'hF; waddr = 1; wd = $urandom;
        tick();
        rst = 0;
        n16 = int'(b16); vseen = v16;
        for (int i = 0; i < 40 && b16; i++) begin
            tick();
            n16 += int'(b16);
            vseen |= v16;
        end
        cmp("restart_len", 32'(n16), 32'd16);
        cmp("clear_no_valid", 32'(vseen), 32'd0);
        idle();

        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 299) == 0;
            clk_en = $urandom_range(0, 4) != 0;
            re = 1'($urandom);
            raddr = 4'($urandom);
            waddr = $urandom_range(0, 1) ? raddr : 4'($urandom);
            we = 4'($urandom);
            wd = $urandom;
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
